kan_spline_neuron: RTL and testbench

Time-multiplexed KAN neuron: accepts a vector of NUM_INPUTS signed samples, evaluates a per-edge piecewise-linear spline on a uniform 2^GRID_LOG2-segment grid for each input from an internal coefficient RAM, and sums the edge outputs into one saturated signed result. It is the next-generation processing element in the KAN layer array. It replaces free-running enable-driven evaluation with valid/ready handshakes on input, output and coefficient load. It adds configurable grid depth, a wide accumulator and saturation reporting.

---
 rtl/kan_pkg.sv | 51 +++++
 rtl/kan_coeff_ram.sv | 31 +++
 rtl/kan_spline_neuron.sv | 190 +++++++++++++++++++
 tb/tb_kan_spline_neuron.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kan_pkg.sv
// Shared definitions for the KAN spline neuron.
//   state_t       : neuron controller states
//   clog2         : ceiling log2 for elaboration-time sizing
//   index_width   : clog2 clamped to at least one bit
//   grid_size     : segments per edge (G)
//   frac_width    : fractional bits of the grid position (FRAC_W)
//   coeff_depth   : coefficient RAM depth (DEPTH)
//   acc_width     : accumulator width that cannot overflow (ACC_WIDTH)
package kan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH0,
        FETCH1,
        MAC,
        DONE
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int index_width(input int n);
        return (clog2(n) > 0) ? clog2(n) : 1;
    endfunction

    function automatic int grid_size(input int grid_log2);
        return 1 << grid_log2;
    endfunction

    function automatic int frac_width(input int data_width, input int grid_log2);
        return data_width - grid_log2;
    endfunction

    function automatic int coeff_depth(input int num_inputs, input int grid_log2);
        return num_inputs * (grid_size(grid_log2) + 1);
    endfunction

    function automatic int acc_width(input int coeff_width, input int num_inputs);
        return coeff_width + 2 + clog2(num_inputs);
    endfunction

endpackage

// File: rtl/kan_coeff_ram.sv
// Coefficient storage: one synchronous write port, one registered read port
// (1-cycle read latency). Contents are intentionally not reset.
//   clk     : clock
//   we      : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address, sampled every cycle
//   rd_data : registered read data
module kan_coeff_ram #(
    parameter int DEPTH       = 36,
    parameter int COEFF_WIDTH = 16,
    parameter int AW          = 6
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [AW-1:0]          wr_addr,
    input  logic [COEFF_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]          rd_addr,
    output logic [COEFF_WIDTH-1:0] rd_data
);

    logic [COEFF_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/kan_spline_neuron.sv
// Time-multiplexed KAN neuron: per-edge piecewise-linear spline lookup from an
// internal coefficient RAM, summed into one saturated signed result.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input vector handshake
//   in_data               : packed samples, edge e at [e*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready   : result handshake
//   out_data, out_sat     : saturated sum and clip flag
//   coeff_we/coeff_ready  : coefficient write handshake
//   coeff_addr/coeff_data : write address e*(G+1)+k and value
module kan_spline_neuron
    import kan_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int GRID_LOG2   = 3,
    parameter int NUM_INPUTS  = 4,
    parameter int ADDR_WIDTH  = 9
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_sat,
    input  logic                             coeff_we,
    output logic                             coeff_ready,
    input  logic [ADDR_WIDTH-1:0]            coeff_addr,
    input  logic [COEFF_WIDTH-1:0]           coeff_data
);

    localparam int G         = grid_size(GRID_LOG2);
    localparam int FRAC_W    = frac_width(DATA_WIDTH, GRID_LOG2);
    localparam int DEPTH     = coeff_depth(NUM_INPUTS, GRID_LOG2);
    localparam int ACC_WIDTH = acc_width(COEFF_WIDTH, NUM_INPUTS);
    localparam int RAM_AW    = index_width(DEPTH);
    localparam int EW        = index_width(NUM_INPUTS);
    localparam int DIFF_W    = COEFF_WIDTH + 1;
    localparam int PROD_W    = DIFF_W + FRAC_W;
    localparam int TERM_W    = COEFF_WIDTH + 2;

    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
    localparam logic [EW-1:0]         LAST_E  = EW'(NUM_INPUTS - 1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    state_t state, state_nxt;
    logic   rst_done;

    logic [NUM_INPUTS*DATA_WIDTH-1:0] x_buf;
    logic [EW-1:0]                    edge_idx;
    logic signed [COEFF_WIDTH-1:0]    c0_q;
    logic signed [COEFF_WIDTH-1:0]    c1;
    logic signed [ACC_WIDTH-1:0]      acc;

    logic [DATA_WIDTH-1:0]         x_cur;
    logic [DATA_WIDTH-1:0]         u_cur;
    logic [GRID_LOG2-1:0]          seg;
    logic [FRAC_W-1:0]             frac;
    logic [RAM_AW-1:0]             base_addr;
    logic [RAM_AW-1:0]             rd_addr;
    logic signed [DIFF_W-1:0]      diff;
    logic signed [PROD_W-1:0]      prod;
    logic signed [PROD_W-1:0]      shifted;
    logic signed [TERM_W-1:0]      term;
    logic signed [ACC_WIDTH-1:0]   acc_sum;
    logic [DATA_WIDTH-1:0]         clip_data;
    logic                          clip_sat;
    logic                          last_edge;
    logic                          ram_we;

    assign ram_we = coeff_we && coeff_ready && (coeff_addr < DEPTH_A);

    kan_coeff_ram #(
        .DEPTH       (DEPTH),
        .COEFF_WIDTH (COEFF_WIDTH),
        .AW          (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (coeff_addr[RAM_AW-1:0]),
        .wr_data (coeff_data),
        .rd_addr (rd_addr),
        .rd_data (c1)
    );

    // Holds in_ready/coeff_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid && rst_done) state_nxt = FETCH0;
            FETCH0:  state_nxt = FETCH1;
            FETCH1:  state_nxt = MAC;
            MAC:     state_nxt = last_edge ? DONE : FETCH0;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state == IDLE) && rst_done;
        coeff_ready = (state == IDLE) && rst_done;
        out_valid   = (state == DONE);
        rd_addr     = base_addr;
        if (state == FETCH1) begin
            rd_addr = base_addr + 1'b1;
        end
    end

    // Grid position: offset-binary sample, top bits pick the segment,
    // remaining bits are the interpolation fraction.
    always_comb begin
        x_cur     = x_buf[edge_idx*DATA_WIDTH +: DATA_WIDTH];
        u_cur     = {~x_cur[DATA_WIDTH-1], x_cur[DATA_WIDTH-2:0]};
        seg       = u_cur[DATA_WIDTH-1 -: GRID_LOG2];
        frac      = u_cur[FRAC_W-1:0];
        base_addr = RAM_AW'(edge_idx) * RAM_AW'(G + 1) + RAM_AW'(seg);
        last_edge = (edge_idx == LAST_E);
    end

    always_comb begin
        diff    = DIFF_W'(c1) - DIFF_W'(c0_q);
        prod    = PROD_W'(diff) * PROD_W'($signed({1'b0, frac}));
        shifted = prod >>> FRAC_W;
        term    = TERM_W'(c0_q) + TERM_W'(shifted);
        acc_sum = acc + ACC_WIDTH'(term);
        clip_sat  = 1'b0;
        clip_data = acc_sum[DATA_WIDTH-1:0];
        if (acc_sum > OUT_MAX) begin
            clip_sat  = 1'b1;
            clip_data = OUT_MAX[DATA_WIDTH-1:0];
        end else if (acc_sum < OUT_MIN) begin
            clip_sat  = 1'b1;
            clip_data = OUT_MIN[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_buf    <= '0;
            edge_idx <= '0;
            c0_q     <= '0;
            acc      <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        x_buf    <= in_data;
                        acc      <= '0;
                        edge_idx <= '0;
                    end
                end
                FETCH1: c0_q <= c1;
                MAC: begin
                    acc <= acc_sum;
                    if (!last_edge) begin
                        edge_idx <= edge_idx + 1'b1;
                    end else begin
                        out_data <= clip_data;
                        out_sat  <= clip_sat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kan_spline_neuron.sv
module tb_kan_spline_neuron;

    localparam int DW  = 16;
    localparam int CW  = 16;
    localparam int GL  = 3;
    localparam int NI  = 4;
    localparam int AW  = 9;
    localparam int G   = 1 << GL;
    localparam int FW  = DW - GL;
    localparam int NC  = NI * (G + 1);
    localparam int LAT = 3 * NI + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [NI*DW-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic             out_sat;
    logic             coeff_we;
    logic             coeff_ready;
    logic [AW-1:0]    coeff_addr;
    logic [CW-1:0]    coeff_data;

    kan_spline_neuron #(
        .DATA_WIDTH  (DW),
        .COEFF_WIDTH (CW),
        .GRID_LOG2   (GL),
        .NUM_INPUTS  (NI),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .coeff_we    (coeff_we),
        .coeff_ready (coeff_ready),
        .coeff_addr  (coeff_addr),
        .coeff_data  (coeff_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          sat;
        int            acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   coef[NC];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW:0] model_out(input logic [NI*DW-1:0] vec);
        longint acc, c0, c1, fr;
        int u, seg;
        logic [DW-1:0] x;
        acc = 0;
        for (int e = 0; e < NI; e++) begin
            x   = vec[e*DW +: DW];
            u   = int'(x ^ 16'h8000);
            seg = u >> FW;
            fr  = longint'(u & ((1 << FW) - 1));
            c0  = coef[e*(G+1) + seg];
            c1  = coef[e*(G+1) + seg + 1];
            acc += c0 + (((c1 - c0) * fr) >>> FW);
        end
        if (acc > 32767) return {1'b1, 16'h7FFF};
        if (acc < -32768) return {1'b1, 16'h8000};
        return {1'b0, acc[DW-1:0]};
    endfunction

    // Output monitor: latency, hold-stability under backpressure, scoreboard pop.
    logic          prev_valid = 1'b0, prev_ready = 1'b0, prev_sat = 1'b0;
    logic [DW-1:0] prev_data = '0;
    exp_t          got_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) check_eq("spurious_valid", out_valid, 0);
                else check_eq("latency", cyc - sb[0].acc_cyc, LAT);
            end
            if (prev_valid && !prev_ready) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_data", out_data, prev_data);
                check_eq("hold_sat", out_sat, prev_sat);
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                got_e = sb.pop_front();
                check_eq("out_data", out_data, got_e.data);
                check_eq("out_sat", out_sat, got_e.sat);
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
            prev_sat   = out_sat;
        end
    end

    // All driver tasks start and end 1ns after a rising edge.
    task automatic write_coeff(input int addr, input int value);
        bit done;
        done       = 0;
        coeff_we   = 1'b1;
        coeff_addr = AW'(addr);
        coeff_data = CW'(value);
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (coeff_ready) done = 1;
            @(posedge clk); #1;
        end
        if (!done) check_eq("coeff_ready_timeout", coeff_ready, 1);
        coeff_we = 1'b0;
        if (done && addr < NC) coef[addr] = int'($signed(CW'(value)));
    endtask

    task automatic load_all(input int value);
        for (int i = 0; i < NC; i++) write_coeff(i, value);
    endtask

    task automatic send(input logic [NI*DW-1:0] vec, input logic [DW-1:0] ed,
                        input logic es, output int acc_at);
        exp_t e;
        bit   done;
        done     = 0;
        acc_at   = -1;
        in_valid = 1'b1;
        in_data  = vec;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.data = ed; e.sat = es; e.acc_cyc = cyc;
                sb.push_back(e);
                acc_at = cyc;
                done   = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) check_eq("accept_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [NI*DW-1:0] vec, output int acc_at);
        logic [DW:0] r;
        r = model_out(vec);
        send(vec, r[DW-1:0], r[DW], acc_at);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        check_eq("drain", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    function automatic logic [NI*DW-1:0] rand_vec();
        return {$urandom, $urandom};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1;
        logic [NI*DW-1:0] v;
        logic [DW:0] r;
        exp_t e;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        coeff_we = 1'b0; coeff_addr = '0; coeff_data = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_coeff_ready", coeff_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_sat", out_sat, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("post_rst_in_ready", in_ready, 1);
        check_eq("post_rst_coeff_ready", coeff_ready, 1);
        @(posedge clk); #1;

        // Constant splines
        load_all(100);
        for (int i = 0; i < 3; i++) send(rand_vec(), 16'd400, 1'b0, t0);
        drain();

        // Interpolation in edge 0, segment 4
        load_all(0);
        write_coeff(4, 0);
        write_coeff(5, 1024);
        v = rand_vec(); v[15:0] = 16'h1000;
        send(v, 16'd512, 1'b0, t0);
        drain();

        // Grid low extreme; out-of-range writes aliasing c[0] must be dropped
        write_coeff(0, -1234);
        write_coeff(64, 7777);
        write_coeff(511, 5555);
        v = rand_vec(); v[15:0] = 16'h8000;
        send(v, 16'hFB2E, 1'b0, t0);
        drain();

        // Grid high extreme
        write_coeff(7, 0);
        write_coeff(8, 8192);
        v = rand_vec(); v[15:0] = 16'h7FFF;
        send(v, 16'd8191, 1'b0, t0);
        drain();

        // Exactly full scale vs one over
        load_all(0);
        write_coeff(0, 32767);
        send({4{16'h8000}}, 16'h7FFF, 1'b0, t0);
        write_coeff(9, 1);
        send({4{16'h8000}}, 16'h7FFF, 1'b1, t0);
        drain();

        // Saturation both rails
        load_all(32767);
        send(rand_vec(), 16'h7FFF, 1'b1, t0);
        drain();
        load_all(-32768);
        send(rand_vec(), 16'h8000, 1'b1, t0);
        drain();

        // Random coefficients, back-to-back transactions
        for (int i = 0; i < NC; i++) write_coeff(i, int'($signed(16'($urandom))));
        send_model(rand_vec(), t0);
        send_model(rand_vec(), t1);
        check_eq("init_interval", t1 - t0, 3 * NI + 2);
        for (int i = 0; i < 3; i++) send_model(rand_vec(), t0);
        drain();

        // Backpressure with input and coefficient writes held asserted
        out_ready = 1'b0;
        send_model(rand_vec(), t0);
        v = rand_vec(); v[31:0] = {16'h8000, 16'h8000};
        in_valid = 1'b1; in_data = v;
        coeff_we = 1'b1; coeff_addr = AW'(9); coeff_data = 16'($urandom);
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        check_eq("bp_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_in_ready", in_ready, 0);
            check_eq("bp_coeff_ready", coeff_ready, 0);
            @(posedge clk); #1;
            coeff_data = 16'($urandom);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1; coeff_addr = AW'(0); coeff_data = 16'h0ABC;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("bp_one_handshake", out_valid, 0);
        check_eq("bp_queued_accept", in_ready, 1);
        check_eq("bp_sb_after", sb.size(), 0);
        coef[0] = 32'h0ABC;
        r = model_out(v);
        e.data = r[DW-1:0]; e.sat = r[DW]; e.acc_cyc = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0; coeff_we = 1'b0;
        drain();

        // Reset during MAC of edge 2
        send_model(rand_vec(), t0);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_in_ready", in_ready, 0);
        check_eq("abort_out_data", out_data, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("abort_no_valid", out_valid, 0);
        end
        @(posedge clk); #1;
        send_model(rand_vec(), t0);
        send_model(rand_vec(), t0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
